// File: rtl/instr_seq_pkg.sv
// Shared state encoding and default sizing for the
// instrumented-adder measurement sequencer.
package instr_seq_pkg;

  localparam int COUNT_W_DEF       = 24;
  localparam int WIN_W_DEF         = 16;
  localparam int SETTLE_CYCLES_DEF = 4;
  localparam int AVG_LOG2_DEF      = 2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    SETTLE  = 3'd2,
    MEASURE = 3'd3,
    CAPTURE = 3'd4,
    DONE    = 3'd5
  } seq_state_e;

endpackage

// File: rtl/instr_adder_seq_ring_edge_counter.sv
// Synchronizes the asynchronous ring output, detects rising edges and counts
// them into a saturating counter with clear/enable and a sticky overflow.
// Ports: wb_clk_i, wb_rst_n (sync, active-low), clr, en, ring_osc_in,
// count[CNT_W], overflow.
module ring_edge_counter
  import instr_seq_pkg::*;
#(
  parameter int CNT_W = COUNT_W_DEF
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             ring_osc_in,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  // [0],[1]: synchronizer, [2]: previous value for edge detect
  logic [2:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             rise;

  always_comb begin
    sync_d = {sync_q[1:0], ring_osc_in};
    rise   = sync_q[1] & ~sync_q[2];
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    if (clr) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (en && rise) begin
      // an edge arriving at all-ones is lost: hold and flag
      if (&cnt_q) ovf_d = 1'b1;
      else        cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      sync_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end

  assign count    = cnt_q;
  assign overflow = ovf_q;

endmodule

// File: rtl/instr_adder_seq.sv
// Measurement sequencer: loads adder operands, runs the ring oscillator for a
// settle period plus a programmable window, counts ring edges, then captures
// the adder sum and edge count.
// Ports: wb_clk_i, wb_rst_n (sync, active-low), active, start, op_a, op_b,
// window, sum_in, ring_osc_in -> adder_a, adder_b, ring_en, busy, done,
// count_out, sum_out, overflow.
// Build option INSTR_SEQ_AVG_EN: repeat MEASURE 2^AVG_LOG2 times and report
// the averaged count.
module instr_adder_seq
  import instr_seq_pkg::*;
#(
  parameter int COUNT_W       = COUNT_W_DEF,
  parameter int WIN_W         = WIN_W_DEF,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int AVG_LOG2      = AVG_LOG2_DEF
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_n,
  input  logic               active,
  input  logic               start,
  input  logic [31:0]        op_a,
  input  logic [31:0]        op_b,
  input  logic [WIN_W-1:0]   window,
  input  logic [31:0]        sum_in,
  input  logic               ring_osc_in,
  output logic [31:0]        adder_a,
  output logic [31:0]        adder_b,
  output logic               ring_en,
  output logic               busy,
  output logic               done,
  output logic [COUNT_W-1:0] count_out,
  output logic [31:0]        sum_out,
  output logic               overflow
);

`ifdef INSTR_SEQ_AVG_EN
  localparam int AW = AVG_LOG2;
`else
  localparam int AW = 0;
`endif
  localparam int ACC_W = COUNT_W + AW;
  localparam int REP_W = AW + 1;
  localparam int ST_W  = $clog2(SETTLE_CYCLES) + 1;

  seq_state_e         state_q, state_d;
  logic [31:0]        adder_a_q, adder_a_d;
  logic [31:0]        adder_b_q, adder_b_d;
  logic [WIN_W-1:0]   win_lat_q, win_lat_d;
  logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
  logic [ST_W-1:0]    settle_q, settle_d;
  logic [REP_W-1:0]   rep_q, rep_d;
  logic               ring_en_q, ring_en_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [COUNT_W-1:0] count_out_q, count_out_d;
  logic [31:0]        sum_out_q, sum_out_d;

  logic               cnt_clr;
  logic               cnt_en;
  logic               last_rep;
  logic [ACC_W-1:0]   acc;
  logic               acc_ovf;

  ring_edge_counter #(
    .CNT_W(ACC_W)
  ) u_cnt (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_n   (wb_rst_n),
    .clr        (cnt_clr),
    .en         (cnt_en),
    .ring_osc_in(ring_osc_in),
    .count      (acc),
    .overflow   (acc_ovf)
  );

  assign last_rep = (rep_q == REP_W'((1 << AW) - 1));

  always_comb begin
    state_d     = state_q;
    adder_a_d   = adder_a_q;
    adder_b_d   = adder_b_q;
    win_lat_d   = win_lat_q;
    win_cnt_d   = win_cnt_q;
    settle_d    = settle_q;
    rep_d       = rep_q;
    ring_en_d   = ring_en_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    count_out_d = count_out_q;
    sum_out_d   = sum_out_q;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;

    if (state_q != IDLE && !active) begin
      // abort: results of the previous run stay visible
      state_d   = IDLE;
      ring_en_d = 1'b0;
      busy_d    = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start && active) begin
            state_d = LOAD;
            busy_d  = 1'b1;
          end
        end
        LOAD: begin
          adder_a_d = op_a;
          adder_b_d = op_b;
          win_lat_d = window;
          settle_d  = ST_W'(SETTLE_CYCLES - 1);
          ring_en_d = 1'b1;
          state_d   = SETTLE;
        end
        SETTLE: begin
          if (settle_q == '0) begin
            cnt_clr   = 1'b1;
            win_cnt_d = win_lat_q;
            rep_d     = '0;
            if (win_lat_q == '0) begin
              ring_en_d = 1'b0;
              state_d   = CAPTURE;
            end else begin
              state_d   = MEASURE;
            end
          end else begin
            settle_d = settle_q - 1'b1;
          end
        end
        MEASURE: begin
          cnt_en    = 1'b1;
          win_cnt_d = win_cnt_q - 1'b1;
          if (win_cnt_q == WIN_W'(1)) begin
            if (last_rep) begin
              ring_en_d = 1'b0;
              state_d   = CAPTURE;
            end else begin
              // next window back-to-back, ring stays on
              rep_d     = rep_q + 1'b1;
              win_cnt_d = win_lat_q;
            end
          end
        end
        CAPTURE: begin
          sum_out_d   = sum_in;
          count_out_d = acc[AW +: COUNT_W];
          done_d      = 1'b1;
          state_d     = DONE;
        end
        DONE: begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
        default: begin
          state_d   = IDLE;
          ring_en_d = 1'b0;
          busy_d    = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      state_q     <= IDLE;
      adder_a_q   <= '0;
      adder_b_q   <= '0;
      win_lat_q   <= '0;
      win_cnt_q   <= '0;
      settle_q    <= '0;
      rep_q       <= '0;
      ring_en_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      count_out_q <= '0;
      sum_out_q   <= '0;
    end else begin
      state_q     <= state_d;
      adder_a_q   <= adder_a_d;
      adder_b_q   <= adder_b_d;
      win_lat_q   <= win_lat_d;
      win_cnt_q   <= win_cnt_d;
      settle_q    <= settle_d;
      rep_q       <= rep_d;
      ring_en_q   <= ring_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      count_out_q <= count_out_d;
      sum_out_q   <= sum_out_d;
    end
  end

  assign adder_a   = adder_a_q;
  assign adder_b   = adder_b_q;
  assign ring_en   = ring_en_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign count_out = count_out_q;
  assign sum_out   = sum_out_q;
  assign overflow  = acc_ovf;

endmodule
